// File: rtl/stream_demux.sv
// 1-to-NUM_CH valid/ready stream demultiplexer with a one-entry register per channel,
// broadcast mode, and a saturating counter for words whose select is out of range.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     drop_pulse
);

  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] load;
  logic              sel_ok;
  logic              accept;
  logic              drop;

  // A channel can take a word if it is empty now or its consumer drains it this cycle.
  assign free = ~out_valid | out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sel_hit[g] = (in_sel == SEL_W'(g));
  end

  // No channel matches when the select is at or beyond NUM_CH.
  assign sel_ok = |sel_hit;

  always_comb begin
    // NOTE: default assignment first so every path drives in_ready and no latch is inferred.
    in_ready = 1'b1;
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = |(sel_hit & free);
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_ok;
  assign load   = {NUM_CH{accept}} & ({NUM_CH{in_bcast}} | sel_hit);

  // NOTE: the channel data registers are reset too, because out_data must read zero
  // during and after reset rather than stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= '0;
      out_data   <= '0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      drop_pulse <= drop;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          out_valid[i]                  <= 1'b1;
          out_data[i*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus a randomized stream,
// all compared against a channel-level behavioural model kept in the bench.
module tb_stream_demux;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data = '0;
  logic [SEL_W-1:0]         in_sel = '0;
  logic                     in_bcast = 1'b0;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready = '0;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     drop_pulse;

  stream_demux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: each channel is just "holding a word or not" plus that word.
  logic [NUM_CH-1:0] m_valid;
  logic [DATA_W-1:0] m_data [NUM_CH];
  int                m_cnt;
  logic              m_pulse;
  logic              m_rdy;
  logic              rdy_seen;

  function automatic logic [NUM_CH*DATA_W-1:0] exp_data();
    logic [NUM_CH*DATA_W-1:0] f;
    for (int i = 0; i < NUM_CH; i++) f[i*DATA_W +: DATA_W] = m_data[i];
    return f;
  endfunction

  task automatic model_reset();
    m_valid = '0;
    for (int i = 0; i < NUM_CH; i++) m_data[i] = '0;
    m_cnt   = 0;
    m_pulse = 1'b0;
  endtask

  // Applies one cycle of stimulus starting just after a rising edge, samples in_ready
  // at the falling edge, then advances the model across the next rising edge.
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s,
                       input logic b, input logic [NUM_CH-1:0] r);
    int si;
    in_valid = v; in_data = d; in_sel = s; in_bcast = b; out_ready = r;
    si = int'(s);
    if (b) begin
      m_rdy = 1'b1;
      for (int i = 0; i < NUM_CH; i++) if (m_valid[i] && !r[i]) m_rdy = 1'b0;
    end else if (si < NUM_CH) begin
      m_rdy = !m_valid[si] || r[si];
    end else begin
      m_rdy = 1'b1;
    end
    #4;
    rdy_seen = in_ready;
    @(posedge clk);
    for (int i = 0; i < NUM_CH; i++) if (m_valid[i] && r[i]) m_valid[i] = 1'b0;
    m_pulse = 1'b0;
    if (v && m_rdy) begin
      if (b) begin
        for (int i = 0; i < NUM_CH; i++) begin m_valid[i] = 1'b1; m_data[i] = d; end
      end else if (si < NUM_CH) begin
        m_valid[si] = 1'b1; m_data[si] = d;
      end else begin
        m_pulse = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if (out_valid !== '0) begin n_err++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
    n_vec++;
    if (out_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data); end
    n_vec++;
    if (drop_cnt !== '0 || drop_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset_drop got cnt=%0d pulse=%b exp 0/0", drop_cnt, drop_pulse);
    end
  endtask

  task automatic test_unicast();
    drive(1'b1, 8'hA5, 4'd4, 1'b0, 8'hFF);
    n_vec++;
    if (rdy_seen !== 1'b1) begin n_err++; $display("FAIL uni_ready got=%b exp=1", rdy_seen); end
    n_vec++;
    if (out_valid !== 8'b0001_0000) begin n_err++; $display("FAIL uni_valid got=%b exp=00010000", out_valid); end
    n_vec++;
    if (out_data[4*DATA_W +: DATA_W] !== 8'hA5) begin
      n_err++; $display("FAIL uni_data got=%h exp=a5", out_data[4*DATA_W +: DATA_W]);
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0, 8'hFF);
    n_vec++;
    if (out_valid !== '0 || out_data !== exp_data()) begin
      n_err++; $display("FAIL uni_pulse got v=%b d=%h exp v=0 d=%h", out_valid, out_data, exp_data());
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'h11, 4'd2, 1'b0, 8'hFB);
    n_vec++;
    if (rdy_seen !== 1'b1 || out_valid !== 8'b0000_0100) begin
      n_err++; $display("FAIL bp_first got rdy=%b v=%b exp rdy=1 v=00000100", rdy_seen, out_valid);
    end
    drive(1'b1, 8'h22, 4'd2, 1'b0, 8'hFB);
    n_vec++;
    if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got=%b exp=0", rdy_seen); end
    n_vec++;
    if (out_data[2*DATA_W +: DATA_W] !== 8'h11) begin
      n_err++; $display("FAIL bp_hold got=%h exp=11", out_data[2*DATA_W +: DATA_W]);
    end
    drive(1'b1, 8'h55, 4'd5, 1'b0, 8'hFB);
    n_vec++;
    if (rdy_seen !== 1'b1 || out_valid !== 8'b0010_0100 || out_data !== exp_data()) begin
      n_err++; $display("FAIL bp_other got rdy=%b v=%b d=%h exp rdy=1 v=00100100 d=%h",
                        rdy_seen, out_valid, out_data, exp_data());
    end
    drive(1'b1, 8'h22, 4'd2, 1'b0, 8'hFF);
    n_vec++;
    if (rdy_seen !== 1'b1 || out_valid !== 8'b0000_0100 || out_data[2*DATA_W +: DATA_W] !== 8'h22) begin
      n_err++; $display("FAIL bp_release got rdy=%b v=%b d2=%h exp rdy=1 v=00000100 d2=22",
                        rdy_seen, out_valid, out_data[2*DATA_W +: DATA_W]);
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0, 8'hFF);
  endtask

  task automatic test_broadcast();
    drive(1'b1, 8'h77, 4'd7, 1'b0, 8'h7F);
    drive(1'b1, 8'h3C, 4'd1, 1'b1, 8'h7F);
    n_vec++;
    if (rdy_seen !== 1'b0 || out_valid !== 8'h80 || out_data !== exp_data()) begin
      n_err++; $display("FAIL bc_blocked got rdy=%b v=%h d=%h exp rdy=0 v=80 d=%h",
                        rdy_seen, out_valid, out_data, exp_data());
    end
    drive(1'b1, 8'h3C, 4'd1, 1'b1, 8'hFF);
    n_vec++;
    if (rdy_seen !== 1'b1 || out_valid !== 8'hFF || out_data !== {NUM_CH{8'h3C}}) begin
      n_err++; $display("FAIL bc_load got rdy=%b v=%h d=%h exp rdy=1 v=ff all 3c", rdy_seen, out_valid, out_data);
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0, 8'hFF);
  endtask

  task automatic test_drop();
    int pulses = 0;
    int bad = 0;
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 8'($urandom), 4'd12, 1'b0, 8'($urandom));
      if (drop_pulse === 1'b1) pulses++;
      if (rdy_seen !== 1'b1 || out_valid !== '0 || drop_pulse !== m_pulse || int'(drop_cnt) != m_cnt)
        bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL drop_cycles got %0d bad cycles exp 0", bad); end
    n_vec++;
    if (pulses != 300) begin n_err++; $display("FAIL drop_pulses got=%0d exp=300", pulses); end
    n_vec++;
    if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
    drive(1'b0, 8'h00, 4'd12, 1'b0, 8'hFF);
    n_vec++;
    if (drop_pulse !== 1'b0 || drop_cnt !== 8'd255) begin
      n_err++; $display("FAIL drop_idle got pulse=%b cnt=%0d exp 0/255", drop_pulse, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] q[$];
    int bad = 0;
    for (int k = 0; k < 24; k++) begin
      logic [DATA_W-1:0] d;
      d = 8'($urandom);
      q.push_back(d);
      drive(1'b1, d, 4'd0, 1'b0, 8'hFF);
      if (rdy_seen !== 1'b1 || out_valid[0] !== 1'b1 || out_data[DATA_W-1:0] !== q.pop_front()) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL b2b_stream got %0d bad cycles exp 0", bad); end
    drive(1'b0, 8'h00, 4'd0, 1'b0, 8'hFF);
  endtask

  task automatic test_random();
    logic              v = 1'b0, b = 1'b0;
    logic [DATA_W-1:0] d = '0;
    logic [SEL_W-1:0]  s = '0;
    logic              held = 1'b0;
    for (int k = 0; k < 600; k++) begin
      // A stalled word stays on the bus unchanged until it is taken.
      if (!held) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
        s = 4'($urandom_range(0, 15));
        b = ($urandom_range(0, 7) == 0);
      end
      drive(v, d, s, b, 8'($urandom));
      held = v && !m_rdy;
      n_vec++;
      if (rdy_seen !== m_rdy || out_valid !== m_valid || out_data !== exp_data() ||
          drop_pulse !== m_pulse || int'(drop_cnt) != m_cnt) begin
        n_err++;
        $display("FAIL rand_%0d got rdy=%b v=%h d=%h p=%b c=%0d exp rdy=%b v=%h d=%h p=%b c=%0d",
                 k, rdy_seen, out_valid, out_data, drop_pulse, drop_cnt,
                 m_rdy, m_valid, exp_data(), m_pulse, m_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h81, 4'd1, 1'b0, 8'h00);
    drive(1'b1, 8'h83, 4'd3, 1'b0, 8'h00);
    drive(1'b1, 8'h00, 4'd14, 1'b0, 8'h00);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (out_valid !== '0 || out_data !== '0) begin
      n_err++; $display("FAIL arst_clear got v=%h d=%h exp 0/0", out_valid, out_data);
    end
    n_vec++;
    if (drop_cnt !== '0 || drop_pulse !== 1'b0) begin
      n_err++; $display("FAIL arst_drop got cnt=%0d pulse=%b exp 0/0", drop_cnt, drop_pulse);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'h5A, 4'd6, 1'b0, 8'hFF);
    n_vec++;
    if (out_valid !== 8'b0100_0000 || out_data !== exp_data()) begin
      n_err++; $display("FAIL arst_after got v=%b d=%h exp v=01000000 d=%h", out_valid, out_data, exp_data());
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_drop();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised 1-to-NUM_CH stream demultiplexer with valid/ready handshaking and a one-entry output register per channel. It routes each accepted input word to the channel selected by `in_sel`, or to every channel in broadcast mode. Words with an out-of-range select are accepted, discarded and counted. It replaces the fixed 1-to-8 combinational demux wherever the consumers can apply backpressure.

## Interface
Parameters:
- `DATA_W`, 8, width of each data word.
- `NUM_CH`, 8, number of output channels; legal range 2..16.
- `SEL_W`, 4, select width; must satisfy 2^SEL_W >= NUM_CH.
- `CNT_W`, 8, width of the drop counter.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept this cycle (combinational).
- `in_data`  in  DATA_W  input word.
- `in_sel`  in  SEL_W  destination channel.
- `in_bcast`  in  1  broadcast; `in_sel` is ignored when set.
- `out_valid`  out  NUM_CH  per-channel word present (registered).
- `out_ready`  in  NUM_CH  per-channel consumer ready.
- `out_data`  out  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W] (registered).
- `drop_cnt`  out  CNT_W  saturating count of dropped words.
- `drop_pulse`  out  1  one-cycle pulse per dropped word (registered).

## Operation
- Each channel is a one-entry buffer with two states, EMPTY and FULL. The state is visible as `out_valid[i]`.
- A channel is free when `!out_valid[i] | out_ready[i]`, i.e. empty now or draining this cycle.
- Acceptance rule: the input is accepted when `in_valid & in_ready`.
- `in_ready` is derived as follows:
  - broadcast (`in_bcast`=1): AND of all channel free flags.
  - unicast with `in_sel` < NUM_CH: the free flag of channel `in_sel`.
  - unicast with `in_sel` >= NUM_CH: 1, so the word is always accepted and dropped.
- Accepted unicast word: loads `out_data[sel]` and sets `out_valid[sel]`. No other channel changes.
- Accepted broadcast word: loads every channel with `in_data` and sets all `out_valid` bits in the same cycle.
- Drain: when `out_valid[i] & out_ready[i]` and channel i is not reloaded, the channel goes FULL -> EMPTY.
- Simultaneous drain and load on one channel: the channel stays FULL and takes the new data. This gives back-to-back throughput of one word per cycle per channel.
- While a channel is FULL and not draining, `out_data[i]` is held stable.
- `out_data` of an EMPTY channel keeps its last value. It is don't-care to consumers, but the bench checks that it does not glitch.
- Dropped word (unicast, `in_sel` >= NUM_CH, accepted):
  - `drop_cnt` increments and saturates at 2^CNT_W-1.
  - `drop_pulse` is asserted for the next cycle.
  - No channel changes.
- A stalled channel blocks only words addressed to it (and broadcasts). Other channels keep flowing.
- `in_valid`=0: no state change. `in_ready` is still driven per the rule above.

## Timing
- Latency: a word accepted at edge N appears on `out_valid`/`out_data` immediately after edge N (one cycle from acceptance).
- `in_ready` is combinational from `in_sel`, `in_bcast`, `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Throughput: one word per cycle whenever the destination channel is free.
- Upstream rule: the producer holds `in_data`, `in_sel` and `in_bcast` stable while `in_valid` is high and `in_ready` is low.
- Downstream rule: once `out_valid[i]` rises, it stays high until `out_ready[i]` is sampled high.
- Reset (`rst_n` low, asynchronous, effective immediately):
  - `out_valid`=0, `out_data`=0.
  - `drop_cnt`=0, `drop_pulse`=0.
  - Any word held in a channel buffer is discarded.
- Reset release: the first acceptance can occur at the first rising edge after `rst_n` goes high.
- Mid-operation reset: FULL channels are cleared without being consumed. The bench must not expect those words.

## Test plan
- Reset, then unicast 0xA5 to `in_sel`=4 with all `out_ready`=1 -> next cycle `out_valid`=8'b0001_0000, channel 4 data 0xA5, one-cycle pulse.
- Hold `out_ready[2]`=0 and send two words (0x11, 0x22) to channel 2 -> first accepted. Then `in_ready`=0 with `out_data[2]`=0x11 stable. A word to channel 5 is still accepted. Releasing `out_ready[2]` accepts 0x22 in the same cycle.
- Broadcast 0x3C with `out_ready[7]`=0 and channel 7 FULL -> `in_ready`=0 and no channel changes. After channel 7 drains, all 8 channels load 0x3C together.
- With NUM_CH=8 and SEL_W=4, send 300 words with `in_sel`=12 -> `in_ready`=1 throughout, `out_valid` stays 0, `drop_pulse` is asserted 300 times, `drop_cnt` saturates at 255.
- Continuous stream to channel 0 with `out_ready[0]`=1 -> one word per cycle, data order preserved, `out_valid[0]` never drops.
- Assert `rst_n`=0 asynchronously mid-cycle while channels 1 and 3 are FULL -> `out_valid` goes to 0 without waiting for a clock edge, `drop_cnt`=0, and the next word after release is delivered normally.
